// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity selectors and line levels.
// Kept separate so the receive side can reuse the same encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    localparam int DATA_WD_DEFAULT = 8;

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity bit for a UART frame; even parity is the XOR of the
// payload, odd parity is its inverse.
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int DATA_WD = DATA_WD_DEFAULT
) (
    input  logic [DATA_WD-1:0] data,
    input  logic               par_typ,
    output logic               par_bit
);

    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one clock per bit. Serialises a byte as start bit, data
// bits LSB first, optional parity bit and one stop bit. o_tx and o_busy are
// registered copies of the values decoded for the next state.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WD = DATA_WD_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [DATA_WD-1:0] i_data,
    input  logic               i_data_valid,
    input  logic               i_par_en,
    input  logic               i_par_typ,
    output logic               o_tx,
    output logic               o_busy
);

    localparam int CNT_W = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WD - 1);

    state_t             state, state_next;
    logic [DATA_WD-1:0] data_q;
    logic [DATA_WD-1:0] shift_q;
    logic [CNT_W-1:0]   cnt;
    logic               par_en_q;
    logic               par_typ_q;
    logic               accept;
    logic               tx_next;
    logic               busy_next;
    logic               par_bit;

    // Parity is derived from the latched byte so later input changes cannot leak in
    uart_tx_parity #(
        .DATA_WD (DATA_WD)
    ) u_parity (
        .data    (data_q),
        .par_typ (par_typ_q),
        .par_bit (par_bit)
    );

    // Next-state decode and next line/busy levels; a new byte is taken only in IDLE or STOP
    always_comb begin
        state_next = IDLE;
        tx_next    = IDLE_LEVEL;
        busy_next  = 1'b0;
        accept     = i_data_valid && (state == IDLE || state == STOP);

        case (state)
            IDLE:    state_next = accept ? START : IDLE;
            START:   state_next = DATA;
            DATA: begin
                if (cnt == CNT_LAST) begin
                    state_next = par_en_q ? PARITY : STOP;
                end else begin
                    state_next = DATA;
                end
            end
            PARITY:  state_next = STOP;
            STOP:    state_next = accept ? START : IDLE;
            default: state_next = IDLE;
        endcase

        // The shift register moves one bit per DATA cycle, so the bit to show
        // next is bit 0 when leaving START and bit 1 while already in DATA.
        case (state_next)
            START:   tx_next = START_LEVEL;
            DATA:    tx_next = (state == START) ? shift_q[0] : shift_q[1];
            PARITY:  tx_next = par_bit;
            STOP:    tx_next = STOP_LEVEL;
            default: tx_next = IDLE_LEVEL;
        endcase

        busy_next = (state_next != IDLE);
    end

    // State, frame latches, shift register, bit counter and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            o_tx      <= IDLE_LEVEL;
            o_busy    <= 1'b0;
            data_q    <= '0;
            shift_q   <= '0;
            cnt       <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
        end else begin
            state  <= state_next;
            o_tx   <= tx_next;
            o_busy <= busy_next;

            if (accept) begin
                data_q    <= i_data;
                shift_q   <= i_data;
                par_en_q  <= i_par_en;
                par_typ_q <= i_par_typ;
            end else if (state == DATA) begin
                shift_q <= {1'b0, shift_q[DATA_WD-1:1]};
            end

            if (state == DATA && cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule
